// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq slice: opcodes, FSM state encoding and
// flag-register bit positions. Used by alu_seq and alu_mul_seq.
package alu_pkg;

  // Opcodes carried on FS
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADC  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_PASS = 4'b0100;
  localparam logic [3:0] OP_KB   = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_MCU  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_SUB  = 4'b1110;
  localparam logic [3:0] OP_AND  = 4'b1111;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  // Bit positions inside the flag register
  localparam int NUM_FLAGS = 5;
  localparam int FLAG_N    = 4;
  localparam int FLAG_Z    = 3;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 1;
  localparam int FLAG_D    = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier for alu_seq. 'load' captures the operands and clears
// the accumulator; each 'step' cycle adds the shifted multiplicand when the
// current multiplier LSB is set. 'finished' is high during the WIDTH-th step,
// and 'product' shows the accumulator value that step will write, so the
// caller can register the full product on the same edge the last step lands.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 finished
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc_next;

  // Next accumulator value for the current step; also the visible product
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  assign product  = acc_next;
  assign finished = step && (cnt == CNT_W'(WIDTH - 1));

  // Operand capture on load, one shift-add iteration per step
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with start/busy/done handshake and a
// persistent N Z C V D flag register.
// Build option: define ALU_SEQ_MUL_EN to include the multi-cycle multiplier
// (opcode 1101). Without it, 1101 is a single-cycle PASS A and busy is 0.
//
// Handshake: start is sampled on a rising edge only while busy=0; all
// operands and the opcode are captured on that edge. done pulses for exactly
// one cycle when F and the flags change. busy=1 while a multiply runs, and a
// start seen then is dropped. start may be high in the done cycle, which
// issues the next operation back-to-back.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SH_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        FS,
  input  logic [SH_W-1:0]   SH,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [WIDTH-1:0]  mcu_input,
  input  logic [WIDTH-1:0]  kb_input,
  output logic [WIDTH-1:0]  F,
  output logic              N,
  output logic              Z,
  output logic              C,
  output logic              V,
  output logic              D,
  output logic              busy,
  output logic              done
);

  logic [NUM_FLAGS-1:0] flags_q;
  logic [NUM_FLAGS-1:0] flags_next;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH-1:0]   b_eff;
  logic               cin;
  logic [WIDTH:0]     sum_w;
  logic [2*WIDTH-1:0] dbl;

  logic [WIDTH-1:0]   res_sel;
  logic               c_sel;
  logic               v_sel;

`ifdef ALU_SEQ_MUL_EN
  logic [0:0]         state;
  logic               mul_load;
  logic               mul_step;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_finished;

  assign busy     = (state == ST_MUL);
  assign mul_load = (state == ST_IDLE) && start && (FS == OP_MUL);
  assign mul_step = (state == ST_MUL);

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (mul_load),
    .step     (mul_step),
    .a        (A),
    .b        (B),
    .product  (mul_product),
    .finished (mul_finished)
  );
`else
  assign busy = 1'b0;
`endif

  // Single-cycle datapath: result plus carry/overflow for the current opcode
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    b_eff   = B;
    cin     = 1'b0;
    sum_w   = '0;
    dbl     = '0;
    case (FS)
      OP_ADD, OP_ADC, OP_SUB: begin
        // SUB is A + ~B + 1, so one adder serves all three
        b_eff   = (FS == OP_SUB) ? ~B : B;
        cin     = (FS == OP_SUB) ? 1'b1 :
                  (FS == OP_ADC) ? flags_q[FLAG_C] : 1'b0;
        sum_w   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (A[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_OR:   alu_res = A | B;
      OP_SLTU: alu_res = (A < B) ? {WIDTH{1'b1}} : '0;
      OP_PASS: alu_res = A;
      OP_KB:   alu_res = kb_input;
      OP_ROL: begin
        // Upper half of {A,A} shifted left is A rotated left
        dbl     = {A, A} << SH;
        alu_res = dbl[2*WIDTH-1:WIDTH];
        alu_c   = (SH != '0) && alu_res[0];
      end
      OP_ROR: begin
        dbl     = {A, A} >> SH;
        alu_res = dbl[WIDTH-1:0];
        alu_c   = (SH != '0) && alu_res[WIDTH-1];
      end
      OP_NOT:  alu_res = ~A;
      OP_SHL: begin
        // The last bit shifted out lands just above the result field
        dbl     = {{WIDTH{1'b0}}, A} << SH;
        alu_res = dbl[WIDTH-1:0];
        alu_c   = (SH != '0) && dbl[WIDTH];
      end
      OP_SHR: begin
        dbl     = {A, {WIDTH{1'b0}}} >> SH;
        alu_res = dbl[2*WIDTH-1:WIDTH];
        alu_c   = (SH != '0) && dbl[WIDTH-1];
      end
      OP_XOR:  alu_res = A ^ B;
      OP_MCU:  alu_res = mcu_input;
      // Without the multiplier this is PASS A; with it, this value is unused
      OP_MUL:  alu_res = A;
      default: alu_res = A & B;
    endcase
  end

  // Pick the value to register (multiplier or single-cycle) and derive flags
  always_comb begin
    res_sel = alu_res;
    c_sel   = alu_c;
    v_sel   = alu_v;
`ifdef ALU_SEQ_MUL_EN
    if (state == ST_MUL) begin
      res_sel = mul_product[WIDTH-1:0];
      c_sel   = |mul_product[2*WIDTH-1:WIDTH];
      v_sel   = |mul_product[2*WIDTH-1:WIDTH];
    end
`endif
    flags_next         = '0;
    flags_next[FLAG_N] = res_sel[WIDTH-1];
    flags_next[FLAG_Z] = (res_sel == '0);
    flags_next[FLAG_C] = c_sel;
    flags_next[FLAG_V] = v_sel;
    flags_next[FLAG_D] = res_sel[WIDTH-1] ^ v_sel;
  end

  // Control FSM, result register and flag register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      F       <= '0;
      flags_q <= '0;
      done    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      state   <= ST_IDLE;
`endif
    end else begin
      done <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (FS == OP_MUL) begin
              state <= ST_MUL;
            end else begin
              F       <= res_sel;
              flags_q <= flags_next;
              done    <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mul_finished) begin
            F       <= res_sel;
            flags_q <= flags_next;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
`else
      if (start) begin
        F       <= res_sel;
        flags_q <= flags_next;
        done    <= 1'b1;
      end
`endif
    end
  end

  assign N = flags_q[FLAG_N];
  assign Z = flags_q[FLAG_Z];
  assign C = flags_q[FLAG_C];
  assign V = flags_q[FLAG_V];
  assign D = flags_q[FLAG_D];

endmodule
